// File: rtl/resize_sched_pkg.sv
// Shared encodings for the resize frame scheduler: FSM states, register word offsets, field bit positions.
package resize_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_RESIZE     = 3'd2,
    S_ACCEL      = 3'd3,
    S_DONE       = 3'd4,
    S_ERR        = 3'd5
  } sched_state_t;

  // Word offsets, i.e. HADDR[4:2]
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_FRAMECNT = 3'd2;
  localparam logic [2:0] REG_DROPCNT  = 3'd3;
  localparam logic [2:0] REG_TIMEOUT  = 3'd4;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_CONT      = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_GO        = 3;
  localparam int STAT_DONE_PEND = 8;
  localparam int STAT_ERR       = 9;

endpackage

// File: rtl/resize_sched_regs.sv
// Zero-wait AHB-Lite register slave for the scheduler: decode, storage, W1C status and read mux.
// TIMEOUT storage exists only with SCHED_TIMEOUT_EN; otherwise it reads 0 and ignores writes.
module resize_sched_regs
  import resize_sched_pkg::*;
#(
  parameter int FCNT_W = 16,
  parameter int TO_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSELS,
  input  logic [31:0]       HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [31:0]       HWDATAS,
  input  logic              HREADYS,
  output logic [31:0]       HRDATAS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  input  logic [2:0]        state,
  input  logic [FCNT_W-1:0] frame_cnt,
  input  logic [7:0]        drop_cnt,
  input  logic              done_set,
  input  logic              err_set,
  output logic              en,
  output logic              cont,
  output logic              go,
  output logic              dropcnt_clr,
  output logic [TO_W-1:0]   timeout,
  output logic              err_pend,
  output logic              irq
);

  logic       wr_pend;
  logic [2:0] addr_q;
  logic       irq_en;
  logic       done_pend;
  logic       wr_ctrl;
  logic       wr_status;
  logic       unused_bits;

  assign HREADYOUTS  = 1'b1;
  assign HRESPS      = 1'b0;
  assign unused_bits = ^{HADDRS[31:5], HADDRS[1:0], HWDATAS};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend <= 1'b0;
      addr_q  <= '0;
    end else begin
      wr_pend <= HSELS & HTRANSS[1] & HWRITES & HREADYS;
      if (HSELS & HTRANSS[1] & HREADYS) addr_q <= HADDRS[4:2];
    end
  end

  assign wr_ctrl     = wr_pend && (addr_q == REG_CTRL);
  assign wr_status   = wr_pend && (addr_q == REG_STATUS);
  assign dropcnt_clr = wr_pend && (addr_q == REG_DROPCNT);
  // GO only launches a frame when the same write also enables the block
  assign go          = wr_ctrl & HWDATAS[CTRL_GO] & HWDATAS[CTRL_EN];

  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      cont      <= 1'b0;
      irq_en    <= 1'b0;
      done_pend <= 1'b0;
      err_pend  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en     <= HWDATAS[CTRL_EN];
        cont   <= HWDATAS[CTRL_CONT];
        irq_en <= HWDATAS[CTRL_IRQ_EN];
      end
      done_pend <= done_set | (done_pend & ~(wr_status & HWDATAS[STAT_DONE_PEND]));
      err_pend  <= err_set  | (err_pend  & ~(wr_status & HWDATAS[STAT_ERR]));
      irq       <= irq_en & (done_pend | err_pend);
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)                                    timeout <= '0;
    else if (wr_pend && addr_q == REG_TIMEOUT)  timeout <= HWDATAS[TO_W-1:0];
  end
`else
  assign timeout = '0;
`endif

  always_comb begin
    HRDATAS = '0;
    case (addr_q)
      REG_CTRL: begin
        HRDATAS[CTRL_EN]     = en;
        HRDATAS[CTRL_CONT]   = cont;
        HRDATAS[CTRL_IRQ_EN] = irq_en;
      end
      REG_STATUS: begin
        HRDATAS[2:0]            = state;
        HRDATAS[STAT_DONE_PEND] = done_pend;
        HRDATAS[STAT_ERR]       = err_pend;
      end
      REG_FRAMECNT: HRDATAS = 32'(frame_cnt);
      REG_DROPCNT:  HRDATAS = 32'(drop_cnt);
      REG_TIMEOUT:  HRDATAS = 32'(timeout);
      default:      HRDATAS = '0;
    endcase
  end

endmodule

// File: rtl/resize_frame_sched.sv
// Frame scheduler: camera frame -> resizer -> accelerator, with frame/drop counters and IRQ.
// Optional watchdog on RESIZE/ACCEL is compiled in with SCHED_TIMEOUT_EN.
module resize_frame_sched
  import resize_sched_pkg::*;
#(
  parameter int FCNT_W = 16,
  parameter int TO_W   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [31:0] HWDATAS,
  input  logic        HREADYS,
  output logic [31:0] HRDATAS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  input  logic        cam_frame_done,
  input  logic        rsz_done,
  input  logic        acc_done,
  output logic        rsz_start,
  output logic        acc_start,
  output logic        cam_hold,
  output logic        irq
);

  sched_state_t      state, state_nxt;
  logic [FCNT_W-1:0] frame_cnt;
  logic [7:0]        drop_cnt;
  logic              en, cont, go, dropcnt_clr, err_pend;
  logic              timeout_hit, done_set, err_set, busy;
  logic [TO_W-1:0]   timeout;

  resize_sched_regs #(.FCNT_W(FCNT_W), .TO_W(TO_W)) u_regs (
    .clk(clk), .rst(rst),
    .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HWDATAS(HWDATAS), .HREADYS(HREADYS), .HRDATAS(HRDATAS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .state(state), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .done_set(done_set), .err_set(err_set),
    .en(en), .cont(cont), .go(go), .dropcnt_clr(dropcnt_clr),
    .timeout(timeout), .err_pend(err_pend), .irq(irq)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // EN is only consulted in WAIT_FRAME and DONE, so a started frame always completes
  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE:       if (go) state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (!en)                 state_nxt = S_IDLE;
        else if (cam_frame_done) state_nxt = S_RESIZE;
      end
      S_RESIZE: begin
        if (timeout_hit) begin
          state_nxt = S_ERR;
          err_set   = 1'b1;
        end else if (rsz_done) begin
          state_nxt = S_ACCEL;
        end
      end
      S_ACCEL: begin
        if (timeout_hit) begin
          state_nxt = S_ERR;
          err_set   = 1'b1;
        end else if (acc_done) begin
          state_nxt = S_DONE;
          done_set  = 1'b1;
        end
      end
      S_DONE:  state_nxt = (en && cont) ? S_WAIT_FRAME : S_IDLE;
      S_ERR:   if (!err_pend) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cam_hold = (state == S_RESIZE);
  assign busy     = (state == S_RESIZE) || (state == S_ACCEL) || (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsz_start <= 1'b0;
      acc_start <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      rsz_start <= (state == S_WAIT_FRAME) && (state_nxt == S_RESIZE);
      acc_start <= (state == S_RESIZE) && (state_nxt == S_ACCEL);
      if (done_set) frame_cnt <= frame_cnt + FCNT_W'(1);
      if (dropcnt_clr)
        drop_cnt <= '0;
      else if (cam_frame_done && busy && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_load;

  assign to_load = ((state_nxt == S_RESIZE) && (state != S_RESIZE)) ||
                   ((state_nxt == S_ACCEL)  && (state != S_ACCEL));

  // A loaded 0 never counts, which is what disables the watchdog
  always_ff @(posedge clk) begin
    if (rst)                to_cnt <= '0;
    else if (to_load)       to_cnt <= timeout;
    else if (to_cnt != '0)  to_cnt <= to_cnt - TO_W'(1);
  end

  assign timeout_hit = ((state == S_RESIZE) || (state == S_ACCEL)) && (to_cnt == TO_W'(1));
`else
  logic unused_to;
  assign unused_to   = ^{timeout, err_pend};
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_resize_frame_sched.sv
// Directed + randomized bench for resize_frame_sched; watchdog checks need SCHED_TIMEOUT_EN defined.
module tb_resize_frame_sched;

  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_FRAMECNT = 32'h08;
  localparam logic [31:0] A_DROPCNT = 32'h0C, A_TIMEOUT = 32'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        HSELS, HWRITES, HREADYS;
  logic [31:0] HADDRS, HWDATAS, HRDATAS;
  logic [1:0]  HTRANSS;
  logic        HREADYOUTS, HRESPS;
  logic        cam_frame_done, rsz_done, acc_done;
  logic        rsz_start, acc_start, cam_hold, irq;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_fcnt = 0;
  logic [31:0] rdata;

  // Reference model state for the random phase
  int m_state, m_fcnt, m_drop;
  bit m_rs, m_as;

  resize_frame_sched #(.FCNT_W(16), .TO_W(24)) dut (
    .clk(clk), .rst(rst),
    .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HWDATAS(HWDATAS), .HREADYS(HREADYS), .HRDATAS(HRDATAS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .cam_frame_done(cam_frame_done), .rsz_done(rsz_done), .acc_done(acc_done),
    .rsz_start(rsz_start), .acc_start(acc_start), .cam_hold(cam_hold), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    HSELS = 1'b1; HTRANSS = 2'b10; HWRITES = 1'b1; HADDRS = a;
    tick();
    HSELS = 1'b0; HTRANSS = 2'b00; HWRITES = 1'b0; HWDATAS = d;
    tick();
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    HSELS = 1'b1; HTRANSS = 2'b10; HWRITES = 1'b0; HADDRS = a;
    tick();
    HSELS = 1'b0; HTRANSS = 2'b00;
    d = HRDATAS;
  endtask

  task automatic cam_pulse(); cam_frame_done = 1'b1; tick(); cam_frame_done = 1'b0; endtask
  task automatic rsz_pulse(); rsz_done = 1'b1; tick(); rsz_done = 1'b0; endtask
  task automatic acc_pulse(); acc_done = 1'b1; tick(); acc_done = 1'b0; endtask

  // One clock of the frame pipeline with EN=CONT=1, expressed as the documented transitions
  task automatic model_step(input bit cam, input bit rd, input bit ad);
    bit busy;
    busy = (m_state == 2) || (m_state == 3) || (m_state == 4);
    if (cam && busy && m_drop < 255) m_drop++;
    m_rs = 1'b0;
    m_as = 1'b0;
    if (m_state == 1 && cam) begin
      m_state = 2; m_rs = 1'b1;
    end else if (m_state == 2 && rd) begin
      m_state = 3; m_as = 1'b1;
    end else if (m_state == 3 && ad) begin
      m_state = 4; m_fcnt++;
    end else if (m_state == 4) begin
      m_state = 1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; HSELS = 0; HADDRS = 0; HTRANSS = 0; HWRITES = 0; HWDATAS = 0; HREADYS = 1'b1;
    cam_frame_done = 0; rsz_done = 0; acc_done = 0;
    ticks(3);
    rst = 1'b0;

    // Reset state
    check_eq("rst_rsz_start", 32'(rsz_start), 0);
    check_eq("rst_acc_start", 32'(acc_start), 0);
    check_eq("rst_cam_hold", 32'(cam_hold), 0);
    check_eq("rst_irq", 32'(irq), 0);
    check_eq("rst_hreadyout", 32'(HREADYOUTS), 1);
    check_eq("rst_hresp", 32'(HRESPS), 0);
    bus_rd(A_STATUS, rdata);   check_eq("rst_status", rdata, 0);
    bus_rd(A_CTRL, rdata);     check_eq("rst_ctrl", rdata, 0);
    bus_rd(A_FRAMECNT, rdata); check_eq("rst_framecnt", rdata, 0);

    // Single shot
    bus_wr(A_CTRL, 32'h0D);
    bus_rd(A_CTRL, rdata);   check_eq("ss_ctrl_go_reads0", rdata, 32'h05);
    bus_rd(A_STATUS, rdata); check_eq("ss_wait_state", rdata & 32'h7, 1);
    cam_pulse();
    check_eq("ss_rsz_start", 32'(rsz_start), 1);
    check_eq("ss_hold_on", 32'(cam_hold), 1);
    tick();
    check_eq("ss_rsz_start_1cyc", 32'(rsz_start), 0);
    rsz_pulse();
    check_eq("ss_acc_start", 32'(acc_start), 1);
    check_eq("ss_hold_off", 32'(cam_hold), 0);
    tick();
    check_eq("ss_acc_start_1cyc", 32'(acc_start), 0);
    acc_pulse(); exp_fcnt++;
    check_eq("ss_irq_lat", 32'(irq), 0);
    tick();
    check_eq("ss_irq", 32'(irq), 1);
    bus_rd(A_STATUS, rdata);   check_eq("ss_status", rdata, 32'h100);
    bus_rd(A_FRAMECNT, rdata); check_eq("ss_framecnt", rdata, 32'(exp_fcnt));

    // Continuous, IRQ disabled
    bus_wr(A_CTRL, 32'h0B);
    for (int f = 0; f < 3; f++) begin
      cam_pulse();
      check_eq("cont_rsz_start", 32'(rsz_start), 1);
      rsz_pulse();
      acc_pulse(); exp_fcnt++;
      tick();
      bus_rd(A_STATUS, rdata);
      check_eq("cont_after_done", rdata & 32'h107, 32'h101);
      check_eq("cont_irq_masked", 32'(irq), 0);
    end
    bus_rd(A_FRAMECNT, rdata); check_eq("cont_framecnt", rdata, 32'(exp_fcnt));
    bus_wr(A_CTRL, 32'h00);
    tick();
    bus_rd(A_STATUS, rdata); check_eq("cont_stop_idle", rdata & 32'h7, 0);

    // W1C race against DONE entry
    bus_wr(A_STATUS, 32'h100);
    bus_rd(A_STATUS, rdata); check_eq("w1c_pre_clear", rdata, 0);
    bus_wr(A_CTRL, 32'h0D);
    cam_pulse();
    rsz_pulse();
    HSELS = 1'b1; HTRANSS = 2'b10; HWRITES = 1'b1; HADDRS = A_STATUS;
    tick();
    HSELS = 1'b0; HTRANSS = 2'b00; HWRITES = 1'b0; HWDATAS = 32'h100; acc_done = 1'b1;
    tick();
    acc_done = 1'b0; exp_fcnt++;
    bus_rd(A_STATUS, rdata); check_eq("w1c_race_set_wins", rdata, 32'h100);
    check_eq("w1c_irq_up", 32'(irq), 1);
    bus_wr(A_STATUS, 32'h100);
    check_eq("w1c_irq_lat", 32'(irq), 1);
    tick();
    check_eq("w1c_irq_fall", 32'(irq), 0);

    // Drop counter saturation while resizing
    bus_wr(A_DROPCNT, 32'h0);
    bus_wr(A_CTRL, 32'h09);
    cam_pulse();
    cam_frame_done = 1'b1;
    ticks(300);
    cam_frame_done = 1'b0;
    bus_rd(A_DROPCNT, rdata); check_eq("drop_sat", rdata, 255);
    bus_rd(A_STATUS, rdata);  check_eq("drop_still_resize", rdata & 32'h7, 2);
    rsz_pulse();
    acc_pulse(); exp_fcnt++;
    tick();
    bus_rd(A_FRAMECNT, rdata); check_eq("drop_framecnt", rdata, 32'(exp_fcnt));
    bus_rd(A_STATUS, rdata);   check_eq("drop_idle", rdata & 32'h7, 0);
    bus_wr(A_DROPCNT, 32'h55);
    bus_rd(A_DROPCNT, rdata);  check_eq("drop_clear", rdata, 0);

    // Disable mid-frame: frame completes, no new launch
    bus_wr(A_CTRL, 32'h0B);
    cam_pulse();
    rsz_pulse();
    bus_wr(A_CTRL, 32'h00);
    acc_pulse(); exp_fcnt++;
    tick();
    cam_pulse();
    check_eq("midop_no_start", 32'(rsz_start), 0);
    tick();
    check_eq("midop_no_hold", 32'(cam_hold), 0);
    bus_rd(A_STATUS, rdata);   check_eq("midop_idle", rdata & 32'h7, 0);
    bus_rd(A_FRAMECNT, rdata); check_eq("midop_framecnt", rdata, 32'(exp_fcnt));

`ifdef SCHED_TIMEOUT_EN
    bus_wr(A_TIMEOUT, 32'd100);
    bus_rd(A_TIMEOUT, rdata); check_eq("to_reg", rdata, 100);
    bus_wr(A_CTRL, 32'h09);
    cam_pulse();
    ticks(99);
    check_eq("to_before", 32'(cam_hold), 1);
    tick();
    check_eq("to_hold_drop", 32'(cam_hold), 0);
    check_eq("to_no_acc_start", 32'(acc_start), 0);
    bus_rd(A_STATUS, rdata); check_eq("to_err_state", rdata & 32'h207, 32'h205);
    bus_wr(A_STATUS, 32'h200);
    tick();
    bus_rd(A_STATUS, rdata); check_eq("to_err_cleared", rdata & 32'h207, 0);
    bus_wr(A_TIMEOUT, 32'd0);
    bus_wr(A_CTRL, 32'h09);
    cam_pulse();
    ticks(10000);
    check_eq("to_zero_hold", 32'(cam_hold), 1);
    bus_rd(A_STATUS, rdata); check_eq("to_zero_noerr", rdata & 32'h207, 32'h002);
    rsz_pulse();
    acc_pulse(); exp_fcnt++;
    tick();
`else
    bus_wr(A_TIMEOUT, 32'h1234);
    bus_rd(A_TIMEOUT, rdata); check_eq("to_absent_reads0", rdata, 0);
`endif

    // Unmapped space
    bus_wr(32'h18, 32'hFFFF_FFFF);
    bus_rd(32'h14, rdata);   check_eq("unmapped_14", rdata, 0);
    bus_rd(32'h18, rdata);   check_eq("unmapped_18", rdata, 0);
    bus_rd(A_CTRL, rdata);   check_eq("unmapped_no_effect", rdata, 0);

    // Randomized event streams in continuous mode against the model
    bus_wr(A_DROPCNT, 32'h0);
    bus_wr(A_CTRL, 32'h0B);
    m_state = 1; m_fcnt = exp_fcnt; m_drop = 0;
    for (int i = 0; i < 400; i++) begin
      bit c, r, a;
      c = ($urandom % 4) == 0;
      r = ($urandom % 3) == 0;
      a = ($urandom % 3) == 0;
      cam_frame_done = c; rsz_done = r; acc_done = a;
      model_step(c, r, a);
      tick();
      check_eq("rnd_hold", 32'(cam_hold), 32'(m_state == 2));
      check_eq("rnd_rsz_start", 32'(rsz_start), 32'(m_rs));
      check_eq("rnd_acc_start", 32'(acc_start), 32'(m_as));
    end
    cam_frame_done = 0; rsz_done = 0; acc_done = 0;
    for (int i = 0; i < 2; i++) begin
      model_step(1'b0, 1'b0, 1'b0);
      tick();
    end
    bus_rd(A_FRAMECNT, rdata); check_eq("rnd_framecnt", rdata, 32'(m_fcnt & 16'hFFFF));
    bus_rd(A_DROPCNT, rdata);  check_eq("rnd_dropcnt", rdata, 32'(m_drop));
    bus_rd(A_STATUS, rdata);   check_eq("rnd_state", rdata & 32'h7, 32'(m_state));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
